// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
// Acquisition and lock sequencer for the TDC-based PLL. Every qualified TDC
// sample is reduced to an unsigned magnitude and steps the loop through
// SETTLE -> ACQUIRE -> TRACK -> LOCKED, with FAULT when acquisition times out.
// All outputs are registered and decoded from the next-state value, so they
// change on the same edge as the state and no input reaches an output
// combinationally.
//
// Handshake: valid is a one-cycle strobe that qualifies tdc in the same cycle.
// There is no backpressure. A sample is consumed only when enable=1 and the
// state is ACQUIRE, TRACK or LOCKED; otherwise it is dropped.
module pll_lock_ctrl #(
   parameter int         WIDTH         = 16,
   parameter int         SETTLE_CYCLES = 64,
   parameter int         ACQ_THRESH    = 64,
   parameter int         LOCK_THRESH   = 8,
   parameter int         UNLOCK_THRESH = 16,
   parameter int         ACQ_COUNT     = 8,
   parameter int         LOCK_COUNT    = 16,
   parameter int         UNLOCK_COUNT  = 4,
   parameter int         ACQ_TIMEOUT   = 1024,
   parameter logic [3:0] P_SHIFT_ACQ   = 4'd2,
   parameter logic [3:0] I_SHIFT_ACQ   = 4'd6,
   parameter logic [3:0] P_SHIFT_TRK   = 4'd4,
   parameter logic [3:0] I_SHIFT_TRK   = 4'd8
) (
   input  logic                    clk,
   input  logic                    ext_rst,
   input  logic                    enable,
   input  logic signed [WIDTH-1:0] tdc,
   input  logic                    valid,
   output logic                    lf_hold,
   output logic [3:0]              p_shift,
   output logic [3:0]              i_shift,
   output logic                    locked,
   output logic                    lock_lost,
   output logic                    fault,
   output logic [2:0]              state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_ACQUIRE = 3'd2,
      ST_TRACK   = 3'd3,
      ST_LOCKED  = 3'd4,
      ST_FAULT   = 3'd5
   } state_t;

   // Thresholds sized to the magnitude; counts sized to the 16-bit counters.
   localparam logic [WIDTH-1:0] ACQ_TH    = WIDTH'(ACQ_THRESH);
   localparam logic [WIDTH-1:0] LOCK_TH   = WIDTH'(LOCK_THRESH);
   localparam logic [WIDTH-1:0] UNLOCK_TH = WIDTH'(UNLOCK_THRESH);
   localparam logic [15:0]      SETTLE_N  = 16'(SETTLE_CYCLES);
   localparam logic [15:0]      ACQ_N     = 16'(ACQ_COUNT);
   localparam logic [15:0]      LOCK_N    = 16'(LOCK_COUNT);
   localparam logic [15:0]      UNLOCK_N  = 16'(UNLOCK_COUNT);
   localparam logic [15:0]      TIMEOUT_N = 16'(ACQ_TIMEOUT);
   localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t      state_q, state_d;
   logic [15:0] settle_cnt_q, settle_cnt_d;
   logic [15:0] close_cnt_q, close_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;
   logic [15:0] timeout_cnt_q, timeout_cnt_d;

   logic        lf_hold_q, lf_hold_d;
   logic [3:0]  p_shift_q, p_shift_d;
   logic [3:0]  i_shift_q, i_shift_d;
   logic        locked_q, locked_d;
   logic        lock_lost_q, lock_lost_d;
   logic        fault_q, fault_d;

   logic [WIDTH-1:0] tdc_u;
   logic [WIDTH-1:0] tdc_mag;

   // Counters saturate at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Unsigned magnitude; the most-negative code maps to 2^(WIDTH-1) exactly
   // because the negation is carried out in unsigned WIDTH-bit arithmetic.
   always_comb begin
      tdc_u   = tdc;
      tdc_mag = tdc_u;
      if (tdc_u[WIDTH-1]) begin
         tdc_mag = ~tdc_u + ONE_W;
      end
   end

   // Next-state and counter update. enable=0 overrides every other transition.
   always_comb begin
      state_d       = state_q;
      settle_cnt_d  = settle_cnt_q;
      close_cnt_d   = close_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      lock_lost_d   = 1'b0;

      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
               // settle_cnt holds the cycles already spent; leave on the last.
               settle_cnt_d = sat_inc(settle_cnt_q);
               if (settle_cnt_d >= SETTLE_N) begin
                  state_d = ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (valid) begin
                  close_cnt_d   = (tdc_mag <= ACQ_TH) ? sat_inc(close_cnt_q) : 16'd0;
                  timeout_cnt_d = sat_inc(timeout_cnt_q);
                  // A sample completing both counts goes to TRACK.
                  if (close_cnt_d >= ACQ_N) begin
                     state_d = ST_TRACK;
                  end else if (timeout_cnt_d >= TIMEOUT_N) begin
                     state_d = ST_FAULT;
                  end
               end
            end
            ST_TRACK: begin
               if (valid) begin
                  if (tdc_mag > ACQ_TH) begin
                     state_d = ST_ACQUIRE;
                  end else if (tdc_mag <= LOCK_TH) begin
                     close_cnt_d = sat_inc(close_cnt_q);
                     if (close_cnt_d >= LOCK_N) begin
                        state_d = ST_LOCKED;
                     end
                  end else begin
                     close_cnt_d = 16'd0;
                  end
               end
            end
            ST_LOCKED: begin
               if (valid) begin
                  if (tdc_mag > UNLOCK_TH) begin
                     miss_cnt_d = sat_inc(miss_cnt_q);
                     if (miss_cnt_d >= UNLOCK_N) begin
                        state_d     = ST_ACQUIRE;
                        lock_lost_d = 1'b1;
                     end
                  end else begin
                     miss_cnt_d = 16'd0;
                  end
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Every state entry starts all counters from zero.
      if (state_d != state_q) begin
         settle_cnt_d  = 16'd0;
         close_cnt_d   = 16'd0;
         miss_cnt_d    = 16'd0;
         timeout_cnt_d = 16'd0;
      end
   end

   // Output decode from the next state so outputs move with the state edge.
   always_comb begin
      lf_hold_d = 1'b0;
      p_shift_d = P_SHIFT_ACQ;
      i_shift_d = I_SHIFT_ACQ;
      locked_d  = 1'b0;
      fault_d   = 1'b0;
      case (state_d)
         ST_IDLE:    lf_hold_d = 1'b1;
         ST_SETTLE:  lf_hold_d = 1'b1;
         ST_ACQUIRE: lf_hold_d = 1'b0;
         ST_TRACK: begin
            p_shift_d = P_SHIFT_TRK;
            i_shift_d = I_SHIFT_TRK;
         end
         ST_LOCKED: begin
            p_shift_d = P_SHIFT_TRK;
            i_shift_d = I_SHIFT_TRK;
            locked_d  = 1'b1;
         end
         ST_FAULT: begin
            lf_hold_d = 1'b1;
            fault_d   = 1'b1;
         end
         default: lf_hold_d = 1'b1;
      endcase
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (ext_rst) begin
         state_q       <= ST_IDLE;
         settle_cnt_q  <= 16'd0;
         close_cnt_q   <= 16'd0;
         miss_cnt_q    <= 16'd0;
         timeout_cnt_q <= 16'd0;
         lf_hold_q     <= 1'b1;
         p_shift_q     <= P_SHIFT_ACQ;
         i_shift_q     <= I_SHIFT_ACQ;
         locked_q      <= 1'b0;
         lock_lost_q   <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         settle_cnt_q  <= settle_cnt_d;
         close_cnt_q   <= close_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
         lf_hold_q     <= lf_hold_d;
         p_shift_q     <= p_shift_d;
         i_shift_q     <= i_shift_d;
         locked_q      <= locked_d;
         lock_lost_q   <= lock_lost_d;
         fault_q       <= fault_d;
      end
   end

   assign state     = state_q;
   assign lf_hold   = lf_hold_q;
   assign p_shift   = p_shift_q;
   assign i_shift   = i_shift_q;
   assign locked    = locked_q;
   assign lock_lost = lock_lost_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl. Each step drives one cycle of stimulus,
// pushes the expected output vector for the following edge, and pops/compares
// it one time unit after that edge.
module tb_pll_lock_ctrl;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SET  = 3'd1;
   localparam logic [2:0] S_ACQ  = 3'd2;
   localparam logic [2:0] S_TRK  = 3'd3;
   localparam logic [2:0] S_LK   = 3'd4;
   localparam logic [2:0] S_FLT  = 3'd5;

   logic               clk = 1'b0;
   logic               ext_rst;
   logic               enable;
   logic signed [15:0] tdc;
   logic               valid;
   logic               lf_hold;
   logic [3:0]         p_shift;
   logic [3:0]         i_shift;
   logic               locked;
   logic               lock_lost;
   logic               fault;
   logic [2:0]         state;

   int          checks = 0;
   int          errors = 0;
   string       phase  = "init";
   logic [14:0] exp_q[$];

   // Clock
   always #5 clk = ~clk;

   pll_lock_ctrl dut (
      .clk       (clk),
      .ext_rst   (ext_rst),
      .enable    (enable),
      .tdc       (tdc),
      .valid     (valid),
      .lf_hold   (lf_hold),
      .p_shift   (p_shift),
      .i_shift   (i_shift),
      .locked    (locked),
      .lock_lost (lock_lost),
      .fault     (fault),
      .state     (state)
   );

   // Expected {state, lf_hold, p_shift, i_shift, locked, lock_lost, fault}
   function automatic logic [14:0] exp_vec(input logic [2:0] st, input logic ll);
      logic hold;
      logic fine;
      hold = (st == S_IDLE) || (st == S_SET) || (st == S_FLT);
      fine = (st == S_TRK) || (st == S_LK);
      return {st, hold, (fine ? 4'd4 : 4'd2), (fine ? 4'd8 : 4'd6),
              (st == S_LK), ll, (st == S_FLT)};
   endfunction

   task automatic check(input logic [14:0] obs, input logic [14:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed {st,hold,p,i,lk,ll,flt}=%h required %h (check %0d)",
                phase, obs, exp, checks);
      end
   endtask

   // Driver: one cycle of stimulus plus scoreboard push/pop.
   task automatic step(input logic en, input logic v, input logic signed [15:0] t,
                       input logic [2:0] es, input logic ll = 1'b0);
      logic [14:0] obs;
      logic [14:0] exp;
      @(negedge clk);
      enable = en;
      valid  = v;
      tdc    = t;
      exp_q.push_back(exp_vec(es, ll));
      @(posedge clk);
      #1;
      obs = {state, lf_hold, p_shift, i_shift, locked, lock_lost, fault};
      exp = exp_q.pop_front();
      check(obs, exp);
   endtask

   // From IDLE with enable=1: 64 cycles reading SETTLE, then ACQUIRE.
   task automatic settle_to_acq();
      phase = "settle";
      for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 16'sd0, S_SET);
      phase = "settle_exit";
      step(1'b1, 1'b0, 16'sd0, S_ACQ);
   endtask

   // Eight close samples in ACQUIRE reach TRACK.
   task automatic acq_to_trk(input logic signed [15:0] t);
      phase = "acq_close";
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, t, S_ACQ);
      phase = "acq_to_trk";
      step(1'b1, 1'b1, t, S_TRK);
   endtask

   initial begin
      ext_rst = 1'b1;
      enable  = 1'b0;
      valid   = 1'b0;
      tdc     = '0;
      repeat (3) @(posedge clk);

      // Reset values, including with enable asserted during reset.
      phase = "reset";
      step(1'b0, 1'b0, 16'sd0, S_IDLE);
      step(1'b1, 1'b1, 16'sd40, S_IDLE);
      ext_rst = 1'b0;
      phase = "idle";
      step(1'b0, 1'b1, 16'sd40, S_IDLE);

      // Settle then acquire, track (with a clear at sample 10), lock.
      settle_to_acq();
      acq_to_trk(16'sd40);
      phase = "trk_close";
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, -16'sd5, S_TRK);
      phase = "trk_clear";
      step(1'b1, 1'b1, 16'sd12, S_TRK);
      phase = "trk_recount";
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, -16'sd5, S_TRK);
      phase = "trk_to_lk";
      step(1'b1, 1'b1, -16'sd5, S_LK);

      // LOCKED: broken miss runs hold lock; |tdc|=16 is not a miss.
      phase = "lk_miss";
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'sd20, S_LK);
      step(1'b1, 1'b1, 16'sd0, S_LK);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'sd20, S_LK);
      step(1'b1, 1'b1, 16'sd16, S_LK);
      step(1'b1, 1'b0, 16'sd20, S_LK);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, -16'sd20, S_LK);
      phase = "lk_lost";
      step(1'b1, 1'b1, 16'sd17, S_ACQ, 1'b1);
      phase = "lk_lost_end";
      step(1'b1, 1'b0, 16'sd0, S_ACQ, 1'b0);

      // TRACK exits on a large sample and on the most-negative code.
      acq_to_trk(16'sd40);
      phase = "trk_big";
      step(1'b1, 1'b1, -16'sd100, S_ACQ);
      acq_to_trk(-16'sd40);
      phase = "trk_minneg";
      step(1'b1, 1'b1, -16'sd32768, S_ACQ);

      // Timeout and close count completing on the same sample: TRACK wins.
      phase = "tie_far";
      for (int i = 0; i < 1016; i++) step(1'b1, 1'b1, 16'sd500, S_ACQ);
      phase = "tie_close";
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 16'sd3, S_ACQ);
      phase = "tie_track";
      step(1'b1, 1'b1, 16'sd3, S_TRK);
      step(1'b1, 1'b1, 16'sd65, S_ACQ);

      // Pure timeout, with non-valid gaps that must not count.
      phase = "timeout";
      for (int i = 0; i < 500; i++) step(1'b1, 1'b1, 16'sd500, S_ACQ);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'sd500, S_ACQ);
      for (int i = 0; i < 523; i++) step(1'b1, 1'b1, 16'sd500, S_ACQ);
      phase = "fault";
      step(1'b1, 1'b1, 16'sd500, S_FLT);
      step(1'b1, 1'b1, 16'sd0, S_FLT);
      step(1'b1, 1'b0, 16'sd0, S_FLT);
      phase = "fault_exit";
      step(1'b0, 1'b0, 16'sd0, S_IDLE);

      // Threshold boundaries in ACQUIRE and TRACK.
      phase = "idle_to_set";
      step(1'b1, 1'b0, 16'sd0, S_SET);
      for (int i = 0; i < 63; i++) step(1'b1, 1'b0, 16'sd0, S_SET);
      step(1'b1, 1'b0, 16'sd0, S_ACQ);
      phase = "acq_bound";
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'sd64, S_ACQ);
      step(1'b1, 1'b1, 16'sd65, S_ACQ);
      acq_to_trk(-16'sd64);
      phase = "trk_bound";
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'sd8, S_TRK);
      step(1'b1, 1'b1, 16'sd64, S_TRK);
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, -16'sd8, S_TRK);
      step(1'b1, 1'b1, 16'sd9, S_TRK);
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, -16'sd8, S_TRK);
      phase = "trk_bound_lk";
      step(1'b1, 1'b1, -16'sd8, S_LK);

      // Disable while LOCKED with a miss on valid: IDLE, no lock_lost.
      phase = "lk_disable";
      step(1'b0, 1'b1, 16'sd20, S_IDLE, 1'b0);
      step(1'b0, 1'b1, 16'sd20, S_IDLE, 1'b0);

      // Reset mid-SETTLE.
      phase = "rst_settle";
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'sd0, S_SET);
      ext_rst = 1'b1;
      phase = "rst_mid";
      step(1'b1, 1'b0, 16'sd0, S_IDLE);
      ext_rst = 1'b0;
      phase = "rst_resume";
      step(1'b1, 1'b0, 16'sd0, S_SET);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
